msk_rnd_lfsr_src: RTL and testbench



---
 rtl/msk_rnd_pkg.sv | 28 ++
 rtl/msk_lfsr_step.sv | 19 +
 rtl/msk_rnd_lfsr_src.sv | 127 ++++++++++++
 tb/tb_msk_rnd_lfsr_src.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_rnd_pkg.sv
// Shared constants, FSM states and LFSR step function
// for the masking fresh-randomness source.
package msk_rnd_pkg;

    localparam int LFSR_LEN   = 128;
    localparam int TAP0       = 127;
    localparam int TAP1       = 125;
    localparam int TAP2       = 100;
    localparam int TAP3       = 98;
    localparam int SEED_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        WARM,
        RUN
    } rnd_fsm_e;

    // x^128 + x^126 + x^101 + x^99 + 1, Fibonacci form
    function automatic logic [LFSR_LEN-1:0] lfsr_next(
        input logic [LFSR_LEN-1:0] s
    );
        logic fb;
        fb = s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
        return {s[LFSR_LEN-2:0], fb};
    endfunction

endpackage

// File: rtl/msk_lfsr_step.sv
// Unrolled N-step advance of the 128-bit LFSR.
// Purely combinational.
module msk_lfsr_step
    import msk_rnd_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [LFSR_LEN-1:0] i_state,
    output logic [LFSR_LEN-1:0] o_state
);

    always_comb begin
        o_state = i_state;
        for (int i = 0; i < N; i++) begin
            o_state = lfsr_next(o_state);
        end
    end

endmodule

// File: rtl/msk_rnd_lfsr_src.sv
// Seeded LFSR fresh-randomness source with seed load,
// warm-up and valid/ready output handshake.
module msk_rnd_lfsr_src
    import msk_rnd_pkg::*;
#(
    parameter int d            = 2,
    parameter int RND_W        = d * (d - 1),
    parameter int WARMUP_STEPS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      seed_data,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic             reseed,
    output logic [RND_W-1:0] rnd,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             busy
);

    localparam int WCW    = $clog2(SEED_WORDS);
    localparam int WARM_W =
        (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;

    rnd_fsm_e            r_fsm;
    logic [LFSR_LEN-1:0] r_state;
    logic [WCW-1:0]      r_word_cnt;
    logic [WARM_W-1:0]   r_warm_cnt;
    logic                r_seed_ready;
    logic                r_rnd_valid;
    logic                r_busy;

    logic [LFSR_LEN-1:0] w_adv;
    logic [LFSR_LEN-1:0] w_seed_next;
    logic                w_seed_zero;
    logic                w_last_word;
    logic                w_last_warm;

    msk_lfsr_step #(
        .N (RND_W)
    ) u_step (
        .i_state (r_state),
        .o_state (w_adv)
    );

    assign w_seed_next = {r_state[LFSR_LEN-33:0], seed_data};
    assign w_seed_zero = (w_seed_next == '0);
    assign w_last_word = (r_word_cnt == WCW'(SEED_WORDS - 1));
    assign w_last_warm = (r_warm_cnt == WARM_W'(WARMUP_STEPS - 1));

    always_comb begin
        rnd = '0;
        for (int k = 0; k < RND_W; k++) begin
            rnd[k] = r_state[LFSR_LEN-1-k];
        end
    end

    assign seed_ready = r_seed_ready;
    assign rnd_valid  = r_rnd_valid;
    assign busy       = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm        <= IDLE;
            r_state      <= '0;
            r_word_cnt   <= '0;
            r_warm_cnt   <= '0;
            r_seed_ready <= 1'b0;
            r_rnd_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else if (reseed) begin
            // Reseed beats any seed word or transfer this cycle
            r_fsm        <= SEED;
            r_word_cnt   <= '0;
            r_warm_cnt   <= '0;
            r_seed_ready <= 1'b1;
            r_rnd_valid  <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            unique case (r_fsm)
                IDLE: begin
                end
                SEED: begin
                    if (seed_valid && r_seed_ready) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (!w_last_word) begin
                            r_state <= w_seed_next;
                        end else begin
                            r_word_cnt   <= '0;
                            r_seed_ready <= 1'b0;
                            r_state      <= w_seed_zero
                                ? LFSR_LEN'(1) : w_seed_next;
                            if (WARMUP_STEPS == 0) begin
                                r_fsm       <= RUN;
                                r_busy      <= 1'b0;
                                r_rnd_valid <= 1'b1;
                            end else begin
                                r_fsm <= WARM;
                            end
                        end
                    end
                end
                WARM: begin
                    r_state <= w_adv;
                    if (w_last_warm) begin
                        r_warm_cnt  <= '0;
                        r_fsm       <= RUN;
                        r_busy      <= 1'b0;
                        r_rnd_valid <= 1'b1;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (r_rnd_valid && rnd_ready) begin
                        r_state <= w_adv;
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msk_rnd_lfsr_src.sv
// Directed table-driven bench for msk_rnd_lfsr_src
// with warm-up and no-warm-up instances.
module tb_msk_rnd_lfsr_src;

    logic        clk;
    logic        rst_n;
    logic [31:0] seed_data;
    logic        seed_valid;
    logic        reseed;
    logic        rnd_ready;

    logic        sr0, rv0, b0;
    logic [1:0]  rnd0;
    logic        sr16, rv16, b16;
    logic [1:0]  rnd16;

    int ntest;
    int nfail;

    msk_rnd_lfsr_src #(
        .d(2), .RND_W(2), .WARMUP_STEPS(0)
    ) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_data  (seed_data),
        .seed_valid (seed_valid),
        .seed_ready (sr0),
        .reseed     (reseed),
        .rnd        (rnd0),
        .rnd_valid  (rv0),
        .rnd_ready  (rnd_ready),
        .busy       (b0)
    );

    msk_rnd_lfsr_src #(
        .d(2), .RND_W(2), .WARMUP_STEPS(16)
    ) u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .seed_data  (seed_data),
        .seed_valid (seed_valid),
        .seed_ready (sr16),
        .reseed     (reseed),
        .rnd        (rnd16),
        .rnd_valid  (rv16),
        .rnd_ready  (rnd_ready),
        .busy       (b16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rs;
        logic        sv;
        logic [31:0] sd;
        logic        rr;
        logic        e_sr;
        logic        e_rv;
        logic        e_b;
        logic [1:0]  e_rnd;
        logic        chk_st;
        logic [127:0] e_st;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [127:0] mstep(
        input logic [127:0] s, input int n);
        logic fb;
        for (int i = 0; i < n; i++) begin
            fb = s[127] ^ s[125] ^ s[100] ^ s[98];
            s  = {s[126:0], fb};
        end
        return s;
    endfunction

    function automatic logic [1:0] mrnd(input logic [127:0] s);
        return {s[126], s[127]};
    endfunction

    task automatic chk(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic rs, input logic sv,
                       input logic [31:0] sd, input logic rr);
        @(negedge clk);
        reseed     = rs;
        seed_valid = sv;
        seed_data  = sd;
        rnd_ready  = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [127:0] m;
    logic [1:0]   hold_rnd;
    logic         found;
    int           bcnt;

    initial begin
        ntest = 0;
        nfail = 0;
        rst_n = 1'b0;
        seed_data = '0;
        seed_valid = 1'b0;
        reseed = 1'b0;
        rnd_ready = 1'b0;

        tbl[0]  = '{"reseed", 1,0,32'h0,        0, 1,0,1,2'b00, 0,128'h0};
        tbl[1]  = '{"w0",     0,1,32'h8000_0000,0, 1,0,1,2'b00, 0,128'h0};
        tbl[2]  = '{"w1",     0,1,32'h0,        0, 1,0,1,2'b00, 0,128'h0};
        tbl[3]  = '{"w2",     0,1,32'h0,        0, 1,0,1,2'b00, 0,128'h0};
        tbl[4]  = '{"w3",     0,1,32'h0,        0, 0,1,0,2'b01, 0,128'h0};
        tbl[5]  = '{"hold",   0,0,32'h0,        0, 0,1,0,2'b01, 0,128'h0};
        tbl[6]  = '{"acc1",   0,0,32'h0,        1, 0,1,0,2'b00, 1,128'h2};
        tbl[7]  = '{"acc2",   0,0,32'h0,        1, 0,1,0,2'b00, 1,128'h8};
        tbl[8]  = '{"rs_rr",  1,0,32'h0,        1, 1,0,1,2'b00, 1,128'h8};
        tbl[9]  = '{"rs_sv",  1,1,32'hFFFF_FFFF,0, 1,0,1,2'b00, 1,128'h8};
        tbl[10] = '{"n0",     0,1,32'h4000_0000,0, 1,0,1,2'b00, 0,128'h0};
        tbl[11] = '{"n1",     0,1,32'h0,        0, 1,0,1,2'b00, 0,128'h0};
        tbl[12] = '{"n2",     0,1,32'h0,        0, 1,0,1,2'b00, 0,128'h0};
        tbl[13] = '{"n3",     0,1,32'h0,        0, 0,1,0,2'b10, 1,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000};
        tbl[14] = '{"acc3",   0,0,32'h0,        1, 0,1,0,2'b00, 1,128'h1};

        // Reset state
        #12;
        chk("rst_sr0",  128'(sr0),  128'(0));
        chk("rst_rv0",  128'(rv0),  128'(0));
        chk("rst_b0",   128'(b0),   128'(0));
        chk("rst_rnd0", 128'(rnd0), 128'(0));
        chk("rst_sr16", 128'(sr16), 128'(0));
        chk("rst_rv16", 128'(rv16), 128'(0));
        chk("rst_b16",  128'(b16),  128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of seeding
        cyc(1, 0, 32'h0, 0);
        cyc(0, 1, 32'h1111_1111, 0);
        cyc(0, 1, 32'h2222_2222, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_sr", 128'(sr0), 128'(0));
        chk("mid_rv", 128'(rv0), 128'(0));
        chk("mid_b",  128'(b0),  128'(0));
        chk("mid_st", u_dut0.r_state, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m = {32'hA5A5_A5A5, 32'h0123_4567,
             32'h89AB_CDEF, 32'h5A5A_5A5A};
        cyc(1, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, m[127-32*i -: 32], 0);
            chk($sformatf("reload_rv%0d", i), 128'(rv0),
                128'(i == 3));
        end
        chk("reload_st", u_dut0.r_state, m);
        chk("reload_rnd", 128'(rnd0), 128'(mrnd(m)));
        do_reset();

        // Directed vector table, no-warm-up instance
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].rs, tbl[i].sv, tbl[i].sd, tbl[i].rr);
            chk({tbl[i].nm, "_sr"},  128'(sr0),  128'(tbl[i].e_sr));
            chk({tbl[i].nm, "_rv"},  128'(rv0),  128'(tbl[i].e_rv));
            chk({tbl[i].nm, "_b"},   128'(b0),   128'(tbl[i].e_b));
            chk({tbl[i].nm, "_rnd"}, 128'(rnd0), 128'(tbl[i].e_rnd));
            if (tbl[i].chk_st)
                chk({tbl[i].nm, "_st"}, u_dut0.r_state, tbl[i].e_st);
        end

        // All-zero seed is replaced by 1
        cyc(1, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h0, 0);
        chk("zero_rv", 128'(rv0), 128'(1));
        chk("zero_st", u_dut0.r_state, 128'h1);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (rnd0 != 2'b00) found = 1'b1;
            else cyc(0, 0, 32'h0, 1);
        end
        if (rnd0 != 2'b00) found = 1'b1;
        chk("zero_nonzero", 128'(found), 128'(1));

        // Backpressure holds rnd, one accept advances 2 steps
        m = {32'hDEAD_BEEF, 32'h1234_5678,
             32'hCAFE_BABE, 32'h0BAD_F00D};
        cyc(1, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, m[127-32*i -: 32], 0);
        chk("bp_rv",   128'(rv0),  128'(1));
        chk("bp_rnd0", 128'(rnd0), 128'(mrnd(m)));
        hold_rnd = mrnd(m);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 32'h0, 0);
            chk($sformatf("bp_hold%0d", i), 128'(rnd0),
                128'(hold_rnd));
        end
        cyc(0, 0, 32'h0, 1);
        m = mstep(m, 2);
        chk("bp_adv_rnd", 128'(rnd0), 128'(mrnd(m)));
        chk("bp_adv_st",  u_dut0.r_state, m);

        // Warm-up instance: 16 busy cycles, then 32-step state
        m = {32'hC001_D00D, 32'h7777_0000,
             32'h0000_8888, 32'h1357_9BDF};
        cyc(1, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, m[127-32*i -: 32], 0);
        seed_valid = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 40 && !rv16; i++) begin
            if (b16) bcnt++;
            @(posedge clk);
            #1;
        end
        chk("warm_busy_cnt", 128'(bcnt), 128'(16));
        chk("warm_rv",  128'(rv16), 128'(1));
        chk("warm_b",   128'(b16),  128'(0));
        chk("warm_rnd", 128'(rnd16), 128'(mrnd(mstep(m, 32))));
        chk("warm_st",  u_dut16.r_state, mstep(m, 32));

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
